// File: rtl/ssr_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssr_calc_pkg
//  Description : Shared constants for the per-antenna signal-strength
//                (power) calculator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssr_calc_pkg;

    // Input sample to ssr output, in clock cycles (S1 regs, S2 squares, S3 sum)
    localparam int SSR_LATENCY = 3;

endpackage : ssr_calc_pkg
`default_nettype wire

// File: rtl/ssr_calc_lane.sv
`default_nettype none
// ============================================================================
//  Module      : ssr_calc_lane
//  Description : One antenna lane: ssr = re^2 + im^2, exact, 3 register stages.
//                Stage enables come from the shared valid pipeline in the top.
//  Ports       : clk, rst        - clock / synchronous active-high reset
//                i_en_s1..s3     - load enables for stage 1, 2, 3
//                i_re, i_im      - signed DATA_WIDTH components
//                o_ssr           - unsigned 2*DATA_WIDTH power
//  Revision    : 1.0 - initial release
// ============================================================================
module ssr_calc_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en_s1,
    input  logic                      i_en_s2,
    input  logic                      i_en_s3,
    input  logic [DATA_WIDTH-1:0]     i_re,
    input  logic [DATA_WIDTH-1:0]     i_im,
    output logic [2*DATA_WIDTH-1:0]   o_ssr
);

    logic signed [DATA_WIDTH-1:0]     r_re;
    logic signed [DATA_WIDTH-1:0]     r_im;
    logic signed [2*DATA_WIDTH-1:0]   w_re_ext;
    logic signed [2*DATA_WIDTH-1:0]   w_im_ext;
    logic signed [2*DATA_WIDTH-1:0]   w_re_sq;
    logic signed [2*DATA_WIDTH-1:0]   w_im_sq;
    logic        [2*DATA_WIDTH-1:0]   r_re_sq;
    logic        [2*DATA_WIDTH-1:0]   r_im_sq;
    logic        [2*DATA_WIDTH-1:0]   r_ssr;

    // Sign-extend before multiplying so the 2*DW product is exact; the largest
    // square, (-2^(DW-1))^2 = 2^(2DW-2), fits without touching the sign bit.
    assign w_re_ext = {{DATA_WIDTH{r_re[DATA_WIDTH-1]}}, r_re};
    assign w_im_ext = {{DATA_WIDTH{r_im[DATA_WIDTH-1]}}, r_im};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    // Every stage loads only when its valid is set, so unqualified (possibly X)
    // input data never enters the datapath and ssr holds between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_re    <= '0;
            r_im    <= '0;
            r_re_sq <= '0;
            r_im_sq <= '0;
            r_ssr   <= '0;
        end else begin
            if (i_en_s1) begin
                r_re <= i_re;
                r_im <= i_im;
            end
            if (i_en_s2) begin
                r_re_sq <= w_re_sq;
                r_im_sq <= w_im_sq;
            end
            if (i_en_s3) begin
                // Sum is at most 2^(2DW-1): fits unsigned 2*DW bits exactly
                r_ssr <= r_re_sq + r_im_sq;
            end
        end
    end

    assign o_ssr = r_ssr;

endmodule : ssr_calc_lane
`default_nettype wire

// File: rtl/ssr_calc.sv
`default_nettype none
// ============================================================================
//  Module      : ssr_calc
//  Description : Per-antenna signal-strength calculator, ssr = re^2 + im^2 for
//                ANTENA_NUM antennas in parallel, fixed 3-cycle latency, one
//                result vector per clock, no backpressure.
//  Ports       : clk, rst   - clock / synchronous active-high reset
//                in_valid   - real_part/imag_part valid this cycle
//                real_part  - packed signed reals, antenna k at [k*DW +: DW]
//                imag_part  - packed signed imags, same packing
//                out_valid  - ssr valid this cycle (in_valid delayed 3)
//                ssr        - packed unsigned results, antenna k at [k*2DW +: 2DW]
//  Revision    : 1.0 - initial release
// ============================================================================
module ssr_calc
    import ssr_calc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ANTENA_NUM = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic [ANTENA_NUM*DATA_WIDTH-1:0]     real_part,
    input  logic [ANTENA_NUM*DATA_WIDTH-1:0]     imag_part,
    output logic                                 out_valid,
    output logic [2*ANTENA_NUM*DATA_WIDTH-1:0]   ssr
);

    // Shared valid pipeline: bit 0 = S1 valid, bit 1 = S2 valid, top bit = S3
    logic [SSR_LATENCY-1:0] r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[SSR_LATENCY-2:0], in_valid};
        end
    end

    assign out_valid = r_vld[SSR_LATENCY-1];

    generate
        for (genvar k = 0; k < ANTENA_NUM; k++) begin : g_lane
            ssr_calc_lane #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .i_en_s1 (in_valid),
                .i_en_s2 (r_vld[0]),
                .i_en_s3 (r_vld[1]),
                .i_re    (real_part[k*DATA_WIDTH +: DATA_WIDTH]),
                .i_im    (imag_part[k*DATA_WIDTH +: DATA_WIDTH]),
                .o_ssr   (ssr[k*2*DATA_WIDTH +: 2*DATA_WIDTH])
            );
        end
    endgenerate

endmodule : ssr_calc
`default_nettype wire

// File: tb/tb_ssr_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssr_calc
//  Description : Self-checking bench for ssr_calc (N=1 and N=4 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssr_calc;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   real_part;
    logic [DW-1:0]   imag_part;
    logic            out_valid;
    logic [2*DW-1:0] ssr;

    logic              in_valid4;
    logic [4*DW-1:0]   real4;
    logic [4*DW-1:0]   imag4;
    logic              out_valid4;
    logic [8*DW-1:0]   ssr4;

    always #5 clk = ~clk;

    ssr_calc #(.DATA_WIDTH(DW), .ANTENA_NUM(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .real_part (real_part),
        .imag_part (imag_part),
        .out_valid (out_valid),
        .ssr       (ssr)
    );

    ssr_calc #(.DATA_WIDTH(DW), .ANTENA_NUM(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .real_part (real4),
        .imag_part (imag4),
        .out_valid (out_valid4),
        .ssr       (ssr4)
    );

    int              n_chk  = 0;
    int              n_fail = 0;
    logic [63:0]     sb_q[$];
    logic [2:0]      m_vld  = '0;
    logic [63:0]     m_hold = '0;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [63:0]   exp;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [63:0] golden(input logic [DW-1:0] re, input logic [DW-1:0] im);
        longint a;
        longint b;
        a = longint'($signed(re));
        b = longint'($signed(im));
        return 64'(a * a + b * b);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock on the N=1 instance: drive, let the edge happen, update the
    // reference model, then check outputs on the following falling edge.
    task automatic cycle(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                         input logic r, input logic [63:0] exp_in);
        rst       = r;
        in_valid  = v;
        real_part = re;
        imag_part = im;
        @(posedge clk);
        if (r) begin
            m_vld  = '0;
            m_hold = '0;
            sb_q.delete();
        end else begin
            m_vld = {m_vld[1:0], v};
            if (v) sb_q.push_back(exp_in);
        end
        @(negedge clk);
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_vld[2]});
        if (m_vld[2]) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_empty: got empty queue required one entry");
            end else begin
                m_hold = sb_q.pop_front();
            end
        end
        chk(m_vld[2] ? "ssr" : "ssr_hold", ssr, m_hold);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom, 1'b0, 64'd0);
    endtask

    initial begin
        logic [DW-1:0] re;
        logic [DW-1:0] im;

        tbl[0] = '{32'd3,        32'd4,        64'd25};
        tbl[1] = '{32'h8000_0000, 32'h8000_0000, 64'h8000_0000_0000_0000};
        tbl[2] = '{32'h7FFF_FFFF, 32'd0,        64'h3FFF_FFFF_0000_0001};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd2};
        tbl[4] = '{32'd0,        32'd0,        64'd0};
        tbl[5] = '{32'hFFFF_FFFB, 32'd12,       64'd169};

        in_valid4 = 1'b0;
        real4     = '0;
        imag4     = '0;

        // Reset held 2 cycles with in_valid high, then 3 idle cycles
        cycle(1'b1, 32'd3, 32'd4, 1'b1, 64'd25);
        cycle(1'b1, 32'd3, 32'd4, 1'b1, 64'd25);
        chk("rst_ssr4_zero", ssr4[63:0], 64'd0);
        chk("rst_out_valid4", {63'd0, out_valid4}, 64'd0);
        idle(3);

        // Single pulse 3+4j -> 25 after 3 cycles, then held
        cycle(1'b1, 32'd3, 32'd4, 1'b0, 64'd25);
        idle(6);

        // Table vectors, back-to-back
        for (int i = 0; i < 6; i++) cycle(1'b1, tbl[i].re, tbl[i].im, 1'b0, tbl[i].exp);
        idle(4);

        // N=4 lane packing: (1,0),(0,-2),(-3,4),(5,-12)
        in_valid4 = 1'b1;
        real4 = {32'd5,         32'hFFFF_FFFD, 32'd0,         32'd1};
        imag4 = {32'hFFFF_FFF4, 32'd4,         32'hFFFF_FFFE, 32'd0};
        idle(1);
        in_valid4 = 1'b0;
        real4 = '1;
        imag4 = '1;
        idle(1);
        chk("n4_early_valid", {63'd0, out_valid4}, 64'd0);
        idle(1);
        chk("n4_out_valid", {63'd0, out_valid4}, 64'd1);
        chk("n4_lane0", ssr4[0*64 +: 64], 64'd1);
        chk("n4_lane1", ssr4[1*64 +: 64], 64'd4);
        chk("n4_lane2", ssr4[2*64 +: 64], 64'd25);
        chk("n4_lane3", ssr4[3*64 +: 64], 64'd169);
        idle(1);
        chk("n4_valid_drop", {63'd0, out_valid4}, 64'd0);
        chk("n4_lane3_hold", ssr4[3*64 +: 64], 64'd169);

        // 100 consecutive random vectors
        for (int i = 0; i < 100; i++) begin
            re = $urandom;
            im = $urandom;
            cycle(1'b1, re, im, 1'b0, golden(re, im));
        end
        // Random gaps; junk data on invalid cycles must not reach ssr
        for (int i = 0; i < 80; i++) begin
            re = $urandom;
            im = $urandom;
            if ($urandom_range(0, 2) != 0) cycle(1'b1, re, im, 1'b0, golden(re, im));
            else                           cycle(1'b0, re, im, 1'b0, 64'd0);
        end
        idle(4);

        // Reset with 3 samples in flight: all discarded, next sample correct
        cycle(1'b1, 32'd11, 32'd13, 1'b0, golden(32'd11, 32'd13));
        cycle(1'b1, 32'd17, 32'd19, 1'b0, golden(32'd17, 32'd19));
        cycle(1'b1, 32'd23, 32'd29, 1'b0, golden(32'd23, 32'd29));
        cycle(1'b1, 32'd31, 32'd37, 1'b1, golden(32'd31, 32'd37));
        cycle(1'b1, 32'd7,  32'd24, 1'b0, 64'd625);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_ssr_calc
`default_nettype wire
